// File: rtl/ram_stream_reader.sv
// Streaming read master for a registered-output block RAM read port.
// Reads LEN consecutive words starting at BASE and presents them in
// address order on a valid/ready stream. A 2-entry buffer hides the
// RAM's one-cycle read latency and absorbs downstream backpressure.
module ram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  CLKIN,
    input  logic                  RESETN,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE,
    input  logic [ADDR_WIDTH:0]   LEN,
    output logic [ADDR_WIDTH-1:0] RADDR,
    output logic                  RE,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DVALID,
    input  logic                  DREADY,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH:0]   issue_rem_q;
    logic                  inflight_q;
    logic [1:0]            count_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf1_q;

    logic                  pop;
    logic [2:0]            occ;
    logic                  last_issue;
    logic                  drain_empty;

    // Stream handshake is decided from registered occupancy, not from DVALID,
    // to keep the issue logic free of combinational feedback.
    assign pop = (count_q != 2'd0) & DREADY;

    // Words that will occupy the buffer after this edge, before any new issue.
    assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign last_issue = (issue_rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1});

    // Empty after this edge: nothing in flight and the buffer drains this cycle.
    assign drain_empty = !inflight_q &&
                         ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

    // State register
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = (LEN == '0) ? StFin : StRead;
                end
            end
            StRead: begin
                if (RE && last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Transition on the final handshake edge so DONE follows it directly.
                if (drain_empty) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        RE     = (state_q == StRead) && (issue_rem_q != '0) && (occ < 3'd2);
        RADDR  = raddr_q;
        DOUT   = buf0_q;
        DVALID = (count_q != 2'd0);
        BUSY   = (state_q != StIdle);
        DONE   = (state_q == StFin);
    end

    // Read address and issue counter
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            raddr_q     <= '0;
            issue_rem_q <= '0;
        end else if ((state_q == StIdle) && START) begin
            raddr_q     <= BASE;
            issue_rem_q <= LEN;
        end else if (RE) begin
            raddr_q     <= raddr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            issue_rem_q <= issue_rem_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

    // Read-data capture into the 2-entry FIFO; buf0_q is always the head
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            inflight_q <= RE;
            case ({inflight_q, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        buf0_q <= RDATA;
                    end else begin
                        buf1_q <= RDATA;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    buf0_q  <= buf1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        buf0_q <= RDATA;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a registered-read RAM model
// preloaded so that word i holds value i.
module tb_ram_stream_reader;

    logic        CLKIN  = 1'b0;
    logic        RESETN = 1'b1;
    logic        START  = 1'b0;
    logic [7:0]  BASE   = 8'h00;
    logic [8:0]  LEN    = 9'd0;
    logic [7:0]  RADDR;
    logic        RE;
    logic [15:0] RDATA  = 16'h0000;
    logic [15:0] DOUT;
    logic        DVALID;
    logic        DREADY = 1'b0;
    logic        BUSY;
    logic        DONE;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [256];

    // Per-burst observation logs
    int          rel;
    int          re_cnt;
    int          done_cnt;
    int          done_rel;
    int          stall_err;
    int          max_out;
    int          dvalid_cnt;
    logic        dvalid_at_done;
    logic        prev_stall;
    logic [15:0] prev_dout;
    logic [15:0] rx[$];
    int          rx_rel[$];
    logic [7:0]  ra[$];
    logic        busy_log[$];

    ram_stream_reader #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16)
    ) dut (
        .CLKIN (CLKIN),
        .RESETN(RESETN),
        .START (START),
        .BASE  (BASE),
        .LEN   (LEN),
        .RADDR (RADDR),
        .RE    (RE),
        .RDATA (RDATA),
        .DOUT  (DOUT),
        .DVALID(DVALID),
        .DREADY(DREADY),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLKIN = ~CLKIN;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    end

    // Registered read port: data appears the cycle after RE
    always @(posedge CLKIN) begin
        if (RE) RDATA <= mem[RADDR];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rel = 0; re_cnt = 0; done_cnt = 0; done_rel = -1; stall_err = 0;
        max_out = 0; dvalid_cnt = 0; dvalid_at_done = 1'bx;
        prev_stall = 1'b0; prev_dout = 16'h0;
        rx.delete(); rx_rel.delete(); ra.delete(); busy_log.delete();
    endtask

    // One clock cycle: apply DREADY, sample settled outputs, advance past the edge
    task automatic cycle_step(input logic rdy);
        DREADY = rdy;
        #1;
        if (RE) begin
            re_cnt++;
            ra.push_back(RADDR);
        end
        if (DVALID) dvalid_cnt++;
        if (prev_stall && (!DVALID || DOUT !== prev_dout)) stall_err++;
        prev_stall = DVALID && !DREADY;
        prev_dout  = DOUT;
        if (DVALID && DREADY) begin
            rx.push_back(DOUT);
            rx_rel.push_back(rel);
        end
        if (DONE) begin
            done_cnt++;
            done_rel       = rel;
            dvalid_at_done = DVALID;
        end
        busy_log.push_back(BUSY);
        if (re_cnt - rx.size() > max_out) max_out = re_cnt - rx.size();
        @(posedge CLKIN);
        #1;
        rel++;
    endtask

    // mode 0: DREADY always high; mode 1: DREADY pattern 1,0,0 repeating.
    // inj: relative cycle at which a stray START with other BASE/LEN is driven.
    task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode,
                             input int inj, input int max_cyc);
        clear_logs();
        BASE  = base;
        LEN   = len;
        START = 1'b1;
        while (done_cnt == 0 && rel < max_cyc) begin
            if (rel == inj) begin
                START = 1'b1;
                BASE  = 8'h99;
                LEN   = 9'd3;
            end else if (rel != 0) begin
                START = 1'b0;
                BASE  = 8'hC3;
                LEN   = 9'd1;
            end
            cycle_step((mode == 0) ? 1'b1 : ((rel % 3) == 0));
        end
        START = 1'b0;
        if (done_cnt != 0) cycle_step(1'b1);
    endtask

    task automatic check_words(input string tag, input logic [7:0] base, input int n);
        int errs;
        errs = 0;
        for (int k = 0; k < n && k < rx.size(); k++) begin
            if (rx[k] !== 16'(8'(base + 8'(k)))) errs++;
        end
        check({tag, "_count"}, 32'(rx.size()), 32'(n));
        check({tag, "_data_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        // Reset state
        #3 RESETN = 1'b0;
        #1;
        check("rst_re", 32'(RE), 32'd0);
        check("rst_raddr", 32'(RADDR), 32'd0);
        check("rst_dout", 32'(DOUT), 32'd0);
        check("rst_dvalid", 32'(DVALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        repeat (2) @(posedge CLKIN);
        #1 RESETN = 1'b1;
        @(posedge CLKIN);
        #1;

        // 1: basic burst timing
        run_burst(8'h10, 9'd4, 0, -1, 40);
        check_words("t1", 8'h10, 4);
        for (int k = 0; k < 4 && k < rx_rel.size(); k++)
            check("t1_word_cycle", 32'(rx_rel[k]), 32'(3 + k));
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_done_cycle", 32'(done_rel), 32'd7);
        check("t1_dvalid_at_done", 32'(dvalid_at_done), 32'd0);
        check("t1_busy_c0", 32'(busy_log[0]), 32'd0);
        check("t1_busy_c1", 32'(busy_log[1]), 32'd1);
        check("t1_busy_c7", 32'(busy_log[7]), 32'd1);
        check("t1_busy_c8", 32'(busy_log[8]), 32'd0);

        // 2: address wrap
        run_burst(8'hFE, 9'd4, 0, -1, 40);
        check_words("t2", 8'hFE, 4);
        check("t2_re_cnt", 32'(re_cnt), 32'd4);
        if (ra.size() == 4) begin
            check("t2_raddr0", 32'(ra[0]), 32'h0FE);
            check("t2_raddr1", 32'(ra[1]), 32'h0FF);
            check("t2_raddr2", 32'(ra[2]), 32'h000);
            check("t2_raddr3", 32'(ra[3]), 32'h001);
        end

        // 3: backpressure
        run_burst(8'h20, 9'd6, 1, -1, 100);
        check_words("t3", 8'h20, 6);
        check("t3_stall_stable", 32'(stall_err), 32'd0);
        check("t3_max_outstanding_le2", 32'(max_out <= 2), 32'd1);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);

        // 4a: zero-length burst
        run_burst(8'h40, 9'd0, 0, -1, 20);
        check("t4a_re_cnt", 32'(re_cnt), 32'd0);
        check("t4a_dvalid_cnt", 32'(dvalid_cnt), 32'd0);
        check("t4a_done_cycle", 32'(done_rel), 32'd1);
        check("t4a_done_cnt", 32'(done_cnt), 32'd1);

        // 4b: START while busy is ignored
        run_burst(8'h30, 9'd8, 0, 3, 60);
        check_words("t4b", 8'h30, 8);
        check("t4b_done_cnt", 32'(done_cnt), 32'd1);
        check("t4b_re_cnt", 32'(re_cnt), 32'd8);
        cycle_step(1'b1);
        cycle_step(1'b1);
        check("t4b_idle_after", 32'(BUSY), 32'd0);
        check("t4b_no_extra_done", 32'(done_cnt), 32'd1);

        // 5: full-range burst
        run_burst(8'h00, 9'd256, 0, -1, 400);
        check_words("t5", 8'h00, 256);
        check("t5_re_cnt", 32'(re_cnt), 32'd256);
        check("t5_done_cnt", 32'(done_cnt), 32'd1);
        check("t5_done_cycle", 32'(done_rel), 32'd259);
        check("t5_max_outstanding_le2", 32'(max_out <= 2), 32'd1);

        // 6: reset mid-burst
        clear_logs();
        BASE  = 8'h50;
        LEN   = 9'd8;
        START = 1'b1;
        while (rx.size() < 2 && rel < 50) begin
            if (rel != 0) START = 1'b0;
            cycle_step(1'b1);
        end
        START = 1'b0;
        check("t6_words_before_reset", 32'(rx.size()), 32'd2);
        RESETN = 1'b0;
        #1;
        check("t6_rst_re", 32'(RE), 32'd0);
        check("t6_rst_raddr", 32'(RADDR), 32'd0);
        check("t6_rst_dout", 32'(DOUT), 32'd0);
        check("t6_rst_dvalid", 32'(DVALID), 32'd0);
        check("t6_rst_busy", 32'(BUSY), 32'd0);
        check("t6_rst_done", 32'(DONE), 32'd0);
        cycle_step(1'b1);
        cycle_step(1'b1);
        RESETN = 1'b1;
        cycle_step(1'b1);
        cycle_step(1'b1);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_idle_after_release", 32'(BUSY), 32'd0);
        run_burst(8'h60, 9'd8, 0, -1, 60);
        check_words("t6_restart", 8'h60, 8);
        check("t6_restart_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_restart_done_cycle", 32'(done_rel), 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
